// File: rtl/midi_msg_rx.sv
// MIDI serial receiver (8N1) with channel-voice message assembly and running status.
// Optional NOTE_ON_VEL0_TO_OFF_EN: emit note-on with velocity 0 as note-off, velocity 0x40.
module midi_msg_rx #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 31250
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MIDI_IN,
  output logic [23:0] MIDI_MSG,
  output logic        MIDI_MSG_RDY,
  output logic        FRAME_ERR
);

  localparam int unsigned Div  = CLK_HZ / BAUD;
  localparam int unsigned Half = Div / 2;
  localparam int unsigned CntW = (Div > 2) ? $clog2(Div) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_ok, ferr_d;

  logic [7:0]      rs_q, rs_d;
  logic            dc_q, dc_d;
  logic [7:0]      d1_q, d1_d;
  logic [23:0]     msg_q, msg_d;
  logic            rdy_q, rdy_d;
  logic            ferr_q;
  logic [23:0]     emit_msg;
  logic            emit;
  logic            rx;

  assign rx = sync_q[1];

  // Synchroniser and edge history reset low so a line already high at release
  // cannot look like a falling edge; only a real high-to-low transition starts a byte.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q  <= 2'b00;
      prev_q  <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      rs_q    <= 8'h00;
      dc_q    <= 1'b0;
      d1_q    <= 8'h00;
      msg_q   <= 24'h0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], MIDI_IN};
      prev_q  <= rx;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rs_q    <= rs_d;
      dc_q    <= dc_d;
      d1_q    <= d1_d;
      msg_q   <= msg_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_ok = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = 3'd0;
        if (prev_q && !rx) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntW'(Half - 1)) begin
          cnt_d   = '0;
          state_d = rx ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntW'(Div - 1)) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntW'(Div - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
          byte_ok = rx;
          ferr_d  = !rx;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rs_d     = rs_q;
    dc_d     = dc_q;
    d1_d     = d1_q;
    emit     = 1'b0;
    emit_msg = 24'h0;
    if (byte_ok) begin
      if (shift_q[7:3] == 5'b11111) begin
        // Realtime bytes are transparent to message assembly.
      end else if (shift_q[7:4] == 4'hF) begin
        rs_d = 8'h00;
        dc_d = 1'b0;
      end else if (shift_q[7]) begin
        rs_d = shift_q;
        dc_d = 1'b0;
      end else if (rs_q[7]) begin
        if (rs_q[7:5] == 3'b110) begin
          emit     = 1'b1;
          emit_msg = {rs_q, shift_q, 8'h00};
          dc_d     = 1'b0;
        end else if (!dc_q) begin
          d1_d = shift_q;
          dc_d = 1'b1;
        end else begin
          emit     = 1'b1;
          emit_msg = {rs_q, d1_q, shift_q};
          dc_d     = 1'b0;
        end
      end
    end
  end

  always_comb begin
    msg_d = msg_q;
    rdy_d = emit;
    if (emit) begin
`ifdef NOTE_ON_VEL0_TO_OFF_EN
      if (emit_msg[23:20] == 4'h9 && emit_msg[7:0] == 8'h00) begin
        msg_d = {4'h8, emit_msg[19:8], 8'h40};
      end else begin
        msg_d = emit_msg;
      end
`else
      msg_d = emit_msg;
`endif
    end
  end

  assign MIDI_MSG     = msg_q;
  assign MIDI_MSG_RDY = rdy_q;
  assign FRAME_ERR    = ferr_q;

endmodule

// File: tb/tb_midi_msg_rx.sv
// Self-checking bench for midi_msg_rx: byte table with a message scoreboard plus
// hand-written reset, framing-error and glitch sequences.
module tb_midi_msg_rx;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 31250;
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned HALF   = DIV / 2;
  // Falling MIDI_IN to visible RDY: 2 sync flops + edge detect, half bit, 9 full bits.
  localparam int unsigned LAT    = 3 + HALF + 9 * DIV;

`ifdef NOTE_ON_VEL0_TO_OFF_EN
  localparam logic [23:0] VEL0_MSG = 24'h804040;
`else
  localparam logic [23:0] VEL0_MSG = 24'h904000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        midi_in = 1'b1;
  logic [23:0] midi_msg;
  logic        midi_msg_rdy;
  logic        frame_err;

  midi_msg_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .MIDI_IN     (midi_in),
    .MIDI_MSG    (midi_msg),
    .MIDI_MSG_RDY(midi_msg_rdy),
    .FRAME_ERR   (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] msg;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [7:0]  b;
    logic        completes;
    logic [23:0] msg;
    logic        glitch_before;
  } vec_t;

  exp_t exp_q[$];
  exp_t e;
  vec_t tbl[16];
  int   tests = 0;
  int   fails = 0;
  int   ferr_cnt = 0;
  logic rdy_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (midi_msg_rdy) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rdy: got msg %h at cycle %0d, required no pulse", midi_msg, cyc);
        end else begin
          e = exp_q.pop_front();
          tests += 2;
          if (midi_msg !== e.msg) begin
            fails++;
            $display("FAIL rdy_msg: got %h, required %h", midi_msg, e.msg);
          end
          if (cyc !== e.cyc) begin
            fails++;
            $display("FAIL rdy_timing: got cycle %0d, required %0d", cyc, e.cyc);
          end
        end
      end
      if (midi_msg_rdy && rdy_prev) begin
        fails++;
        $display("FAIL rdy_back_to_back: got 2 consecutive pulses, required 1");
      end
      if (midi_msg_rdy && frame_err) begin
        fails++;
        $display("FAIL rdy_with_ferr: got both high, required at most one");
      end
      if (frame_err) ferr_cnt++;
    end
    rdy_prev = midi_msg_rdy;
  end

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Called on a negedge; returns on a negedge with the line idle high.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic completes,
                           input logic [23:0] msg);
    exp_t x;
    if (completes) begin
      x.msg = msg;
      x.cyc = cyc + LAT;
      exp_q.push_back(x);
    end
    midi_in = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_in = b[i];
      repeat (DIV) @(negedge clk);
    end
    midi_in = stop_ok;
    repeat (DIV) @(negedge clk);
    midi_in = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    midi_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, required finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{8'h90, 1'b0, 24'h0, 1'b0};
    tbl[1]  = '{8'h3C, 1'b0, 24'h0, 1'b0};
    tbl[2]  = '{8'h64, 1'b1, 24'h903C64, 1'b0};
    tbl[3]  = '{8'h90, 1'b0, 24'h0, 1'b0};
    tbl[4]  = '{8'h3C, 1'b0, 24'h0, 1'b0};
    tbl[5]  = '{8'h64, 1'b1, 24'h903C64, 1'b0};
    tbl[6]  = '{8'h40, 1'b0, 24'h0, 1'b0};
    tbl[7]  = '{8'h00, 1'b1, VEL0_MSG, 1'b0};
    tbl[8]  = '{8'hC5, 1'b0, 24'h0, 1'b0};
    tbl[9]  = '{8'hF8, 1'b0, 24'h0, 1'b0};
    tbl[10] = '{8'h07, 1'b1, 24'hC50700, 1'b0};
    tbl[11] = '{8'hF0, 1'b0, 24'h0, 1'b1};
    tbl[12] = '{8'h3C, 1'b0, 24'h0, 1'b0};
    tbl[13] = '{8'h64, 1'b0, 24'h0, 1'b0};
    tbl[14] = '{8'hF7, 1'b0, 24'h0, 1'b0};
    tbl[15] = '{8'h3C, 1'b0, 24'h0, 1'b0};

    do_reset();
    chk("reset_msg", midi_msg, 24'h0);
    chk("reset_rdy", {23'h0, midi_msg_rdy}, 24'h0);
    chk("reset_ferr", {23'h0, frame_err}, 24'h0);

    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].glitch_before) begin
        // 0.4-bit low pulse must be rejected at the half-bit check.
        midi_in = 1'b0;
        repeat ((DIV * 2) / 5) @(negedge clk);
        midi_in = 1'b1;
        repeat (2 * DIV) @(negedge clk);
      end
      send_byte(tbl[i].b, 1'b1, tbl[i].completes, tbl[i].msg);
    end
    repeat (2 * DIV) @(negedge clk);
    chk("stream_pending", 24'(exp_q.size()), 24'h0);
    chk("stream_ferr_cnt", 24'(ferr_cnt), 24'h0);
    chk("msg_held", midi_msg, 24'hC50700);

    // Reset in the middle of the byte that would complete 90 3C 64.
    send_byte(8'h90, 1'b1, 1'b0, 24'h0);
    send_byte(8'h3C, 1'b1, 1'b0, 24'h0);
    midi_in = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_msg", midi_msg, 24'h0);
    chk("midrst_rdy", {23'h0, midi_msg_rdy}, 24'h0);
    chk("midrst_ferr", {23'h0, frame_err}, 24'h0);
    @(negedge clk);
    midi_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (12 * DIV) @(negedge clk);
    chk("midrst_pending", 24'(exp_q.size()), 24'h0);
    chk("midrst_msg_after", midi_msg, 24'h0);

    // Framing error on a status byte, then data with no running status.
    ferr_cnt = 0;
    send_byte(8'h90, 1'b0, 1'b0, 24'h0);
    repeat (DIV) @(negedge clk);
    send_byte(8'h3C, 1'b1, 1'b0, 24'h0);
    send_byte(8'h64, 1'b1, 1'b0, 24'h0);
    repeat (2 * DIV) @(negedge clk);
    chk("ferr_cnt", 24'(ferr_cnt), 24'h1);
    chk("ferr_pending", 24'(exp_q.size()), 24'h0);
    chk("ferr_msg", midi_msg, 24'h0);

    // Running status survives; a fresh pair after reset-free status emits normally.
    send_byte(8'hD2, 1'b1, 1'b0, 24'h0);
    send_byte(8'h11, 1'b1, 1'b1, 24'hD21100);
    send_byte(8'h22, 1'b1, 1'b1, 24'hD22200);
    repeat (2 * DIV) @(negedge clk);
    chk("chanpress_pending", 24'(exp_q.size()), 24'h0);
    chk("chanpress_msg", midi_msg, 24'hD22200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
